// File: rtl/stopwatch_pkg.sv
// Shared constants and channel state type for the stopwatch key conditioner.
// Cycle counts assume the 50 MHz board clock.
package stopwatch_pkg;

  localparam int DEBOUNCE_20MS      = 1_000_000;
  localparam int REPEAT_DELAY_0_5S  = 25_000_000;
  localparam int REPEAT_PERIOD_0_1S = 5_000_000;

  typedef enum logic [1:0] {
    KEY_RELEASED  = 2'd0,
    KEY_HELD_WAIT = 2'd1,
    KEY_REPEATING = 2'd2
  } key_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: two-flop synchroniser, debounce counter, press/repeat FSM.
// All event outputs are registered single-cycle pulses.
//
// state          | meaning
// KEY_RELEASED   | debounced level is released, no repeat activity
// KEY_HELD_WAIT  | held, counting towards the first repeat
// KEY_REPEATING  | held, repeat pulses at the period rate
module key_channel
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = DEBOUNCE_20MS,
  parameter int REPEAT_DELAY_CYCLES  = REPEAT_DELAY_0_5S,
  parameter int REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_0_1S
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  input  logic repeat_en,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = max_int(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES);
  localparam int RW   = ($clog2(RMAX) < 1) ? 1 : $clog2(RMAX);

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [DW-1:0] db_cnt, db_cnt_next;
  logic          level_next, toggle;
  key_state_e    state, state_next;
  logic [RW-1:0] rpt_cnt, rpt_cnt_next, rpt_last;
  logic          press_next, release_next, repeat_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q      <= '0;
      db_cnt      <= '0;
      key_level   <= 1'b0;
      state       <= KEY_RELEASED;
      rpt_cnt     <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], ~key_n};
      db_cnt      <= db_cnt_next;
      key_level   <= level_next;
      state       <= state_next;
      rpt_cnt     <= rpt_cnt_next;
      key_press   <= press_next;
      key_release <= release_next;
      key_repeat  <= repeat_next;
    end
  end

  always_comb begin
    db_cnt_next  = '0;
    level_next   = key_level;
    toggle       = 1'b0;
    state_next   = state;
    rpt_cnt_next = rpt_cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    repeat_next  = 1'b0;
    rpt_last     = (state == KEY_HELD_WAIT) ? DELAY_LAST : PERIOD_LAST;

    // Any cycle where the synced input agrees with the level restarts the count.
    if (sync_q[1] != key_level) begin
      if (db_cnt == DB_LAST) begin
        toggle     = 1'b1;
        level_next = ~key_level;
      end else begin
        db_cnt_next = db_cnt + DW'(1);
      end
    end

    if (toggle && !key_level) begin
      state_next   = KEY_HELD_WAIT;
      rpt_cnt_next = '0;
      press_next   = 1'b1;
    end else if (toggle && key_level) begin
      state_next   = KEY_RELEASED;
      rpt_cnt_next = '0;
      release_next = 1'b1;
    end else begin
      case (state)
        KEY_RELEASED: rpt_cnt_next = '0;
        KEY_HELD_WAIT, KEY_REPEATING: begin
          if (!repeat_en) begin
            rpt_cnt_next = '0;
          end else if (rpt_cnt == rpt_last) begin
            rpt_cnt_next = '0;
            repeat_next  = 1'b1;
            state_next   = KEY_REPEATING;
          end else begin
            rpt_cnt_next = rpt_cnt + RW'(1);
          end
        end
        default: begin
          state_next   = KEY_RELEASED;
          rpt_cnt_next = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/stopwatch_key_conditioner.sv
// Board KEY conditioner: one independent key_channel per key, producing
// debounced levels and press/release/auto-repeat pulses.
module stopwatch_key_conditioner
  import stopwatch_pkg::*;
#(
  parameter int NUM_KEYS             = 2,
  parameter int DEBOUNCE_CYCLES      = DEBOUNCE_20MS,
  parameter int REPEAT_DELAY_CYCLES  = REPEAT_DELAY_0_5S,
  parameter int REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_0_1S
) (
  input  logic                CLK_50MHz,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NUM_KEYS-1:0] repeat_en,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
    ) u_channel (
      .clk         (CLK_50MHz),
      .reset_n     (reset_n),
      .key_n       (key_n[i]),
      .repeat_en   (repeat_en[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_repeat  (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_stopwatch_key_conditioner.sv
// Scoreboard bench: a cycle-level reference model pushes expected events,
// a negedge monitor pops and compares whenever the DUT emits a pulse.
module tb_stopwatch_key_conditioner;

  localparam int NK = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_REPEAT  = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NK-1:0] key_n;
  logic [NK-1:0] repeat_en;
  logic [NK-1:0] key_level, key_press, key_release, key_repeat;

  stopwatch_key_conditioner #(
    .NUM_KEYS             (NK),
    .DEBOUNCE_CYCLES      (DB),
    .REPEAT_DELAY_CYCLES  (RD),
    .REPEAT_PERIOD_CYCLES (RP)
  ) dut (
    .CLK_50MHz   (clk),
    .reset_n     (reset_n),
    .key_n       (key_n),
    .repeat_en   (repeat_en),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  ev_t exp_q[NK][$];
  int  cyc = 0;
  int  checks = 0;
  int  passed = 0;

  task automatic chk(input string name, input int key, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s key%0d cycle %0d: got %0d expected %0d", name, key, cyc, act, exp);
  endtask

  // Reference model: sync is the raw pressed state two edges late; a level
  // change is accepted after DB consecutive disagreeing edges. Repeats fire
  // when the enabled hold time since the last press/repeat reaches the
  // threshold (delay for the first, period afterwards).
  int m_s1[NK], m_s2[NK], m_lvl[NK], m_run[NK];
  int m_held[NK], m_since[NK], m_nrep[NK];
  int sync_now, thr;
  bit accepted;

  initial begin
    for (int i = 0; i < NK; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
      m_held[i] = 0; m_since[i] = 0; m_nrep[i] = 0;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < NK; i++) begin
      if (!reset_n) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
        m_held[i] = 0; m_since[i] = 0; m_nrep[i] = 0;
      end else begin
        sync_now = m_s2[i];
        m_s2[i]  = m_s1[i];
        m_s1[i]  = key_n[i] ? 0 : 1;
        accepted = 1'b0;
        if (sync_now != m_lvl[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DB) begin
            m_run[i] = 0;
            m_lvl[i] = sync_now;
            accepted = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
        if (accepted && m_lvl[i] == 1) begin
          m_held[i] = 1; m_since[i] = 0; m_nrep[i] = 0;
          exp_q[i].push_back('{cyc: cyc, kind: EV_PRESS});
        end else if (accepted) begin
          m_held[i] = 0;
          exp_q[i].push_back('{cyc: cyc, kind: EV_RELEASE});
        end else if (m_held[i] == 1) begin
          if (!repeat_en[i]) begin
            m_since[i] = 0;
          end else begin
            m_since[i] = m_since[i] + 1;
            thr = (m_nrep[i] == 0) ? RD : RP;
            if (m_since[i] == thr) begin
              m_since[i] = 0;
              m_nrep[i]  = m_nrep[i] + 1;
              exp_q[i].push_back('{cyc: cyc, kind: EV_REPEAT});
            end
          end
        end
      end
    end
  end

  // Monitor
  int np, kind_seen;
  always @(negedge clk) begin
    for (int i = 0; i < NK; i++) begin
      while (exp_q[i].size() > 0 && exp_q[i][0].cyc < cyc) begin
        chk("missed_event_cycle", i, cyc, exp_q[i][0].cyc);
        void'(exp_q[i].pop_front());
      end
      np = int'(key_press[i]) + int'(key_release[i]) + int'(key_repeat[i]);
      if (np > 0) begin
        chk("pulse_exclusive", i, np, 1);
        kind_seen = key_press[i] ? EV_PRESS : (key_release[i] ? EV_RELEASE : EV_REPEAT);
        if (exp_q[i].size() > 0 && exp_q[i][0].cyc == cyc) begin
          chk("event_kind", i, kind_seen, exp_q[i][0].kind);
          void'(exp_q[i].pop_front());
        end else begin
          chk("unexpected_event_cycle", i, cyc, (exp_q[i].size() > 0) ? exp_q[i][0].cyc : -1);
        end
      end
      chk("key_level", i, int'(key_level[i]), m_lvl[i]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int hold_left[NK];

  initial begin
    reset_n   = 1'b0;
    key_n     = 2'b00;
    repeat_en = 2'b00;
    // 1. reset with keys held, then re-acceptance
    step(3);
    chk("reset_outputs", 0, int'({key_level, key_press, key_release, key_repeat}), 0);
    step(1);
    chk("reset_outputs", 1, int'({key_level, key_press, key_release, key_repeat}), 0);
    reset_n = 1'b1;
    step(12);
    key_n = 2'b11;
    step(12);
    // 2. clean press/release on key0
    key_n[0] = 1'b0; step(8);
    key_n[0] = 1'b1; step(10);
    // 3. bounce shorter than the debounce window
    for (int j = 0; j < 10; j++) begin
      key_n[0] = ~key_n[0];
      step(2);
    end
    key_n[0] = 1'b1; step(10);
    // 4. auto-repeat enabled, then disabled
    repeat_en = 2'b01;
    key_n[0] = 1'b0; step(35);
    key_n[0] = 1'b1; step(12);
    repeat_en = 2'b00;
    key_n[0] = 1'b0; step(35);
    key_n[0] = 1'b1; step(12);
    // 4b. repeat_en dropped mid-hold restarts the count
    repeat_en = 2'b01;
    key_n[0] = 1'b0; step(14);
    repeat_en = 2'b00; step(4);
    repeat_en = 2'b01; step(25);
    key_n[0] = 1'b1; step(12);
    // 5. simultaneous keys, offset by 2 cycles
    repeat_en = 2'b11;
    key_n[0] = 1'b0; step(2);
    key_n[1] = 1'b0; step(25);
    key_n = 2'b11; step(12);
    // 6. reset while repeating
    key_n[0] = 1'b0; step(22);
    reset_n = 1'b0; step(1);
    chk("midreset_outputs", 0, int'({key_level, key_press, key_release, key_repeat}), 0);
    reset_n = 1'b1; step(20);
    key_n[0] = 1'b1; step(12);
    // Randomised bounce, holds, repeat_en changes and occasional reset
    for (int i = 0; i < NK; i++) hold_left[i] = 0;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < NK; i++) begin
        if (hold_left[i] == 0) begin
          key_n[i] = 1'($urandom_range(0, 1));
          hold_left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                    : int'($urandom_range(4, 30));
        end else begin
          hold_left[i] = hold_left[i] - 1;
        end
        if ($urandom_range(0, 39) == 0) repeat_en[i] = ~repeat_en[i];
      end
      reset_n = ($urandom_range(0, 299) != 0);
      step(1);
    end
    reset_n   = 1'b1;
    key_n     = 2'b11;
    repeat_en = 2'b00;
    step(20);
    for (int i = 0; i < NK; i++) chk("leftover_expected", i, exp_q[i].size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, checks);
    $fatal(1);
  end

endmodule

// File: doc/stopwatch_key_conditioner.md
# stopwatch_key_conditioner

Input-side conditioner for the stopwatch push-buttons. It takes the raw, active-low, asynchronous KEY inputs from the board and produces clean, single-cycle command pulses for the stopwatch control logic. It runs in the 50 MHz domain, between the board pins and the 100 Hz stopwatch logic. It synchronises and debounces each key, then emits press, release and auto-repeat events; auto-repeat drives fast digit increment in adjustment mode.

## Interface
Parameters:
- NUM_KEYS, 2, number of independent keys (start_stop, hold).
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); legal range ≥ 2.
- REPEAT_DELAY_CYCLES, 25_000_000, held time before the first repeat pulse (0.5 s).
- REPEAT_PERIOD_CYCLES, 5_000_000, spacing between subsequent repeat pulses (0.1 s).

Ports:
- CLK_50MHz  in  1  system clock; one clock domain only.
- reset_n  in  1  synchronous, active-low reset, sampled on the CLK_50MHz rising edge.
- key_n  in  NUM_KEYS  raw board keys, active-low, asynchronous, bouncy.
- repeat_en  in  NUM_KEYS  per-key auto-repeat enable (tied high only in adjustment mode).
- key_level  out  NUM_KEYS  debounced pressed state, 1 = pressed.
- key_press  out  NUM_KEYS  1-cycle pulse on accepted press.
- key_release  out  NUM_KEYS  1-cycle pulse on accepted release.
- key_repeat  out  NUM_KEYS  1-cycle auto-repeat pulse while held.

## Operation
- Each key is handled by an independent, identical channel. There is no interaction between keys; simultaneous presses are handled independently.
- Synchroniser: two flops on inverted key_n, so sync = 1 means pressed. Both flops reset to 0 (released).
- Debounce counter, width clog2(DEBOUNCE_CYCLES+1):
  - While sync equals key_level, the counter is 0.
  - While sync differs from key_level, the counter increments.
  - Any cycle where sync equals key_level again clears the counter (bounce rejection).
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, key_level toggles on the next edge and the counter clears.
- Channel FSM: RELEASED, HELD_WAIT, REPEATING.
  - RELEASED -> HELD_WAIT on accepted press; key_press pulses. The repeat counter loads 0.
  - HELD_WAIT: the repeat counter increments each cycle. When it reaches REPEAT_DELAY_CYCLES-1 and repeat_en = 1, key_repeat pulses, the counter clears, and the FSM goes to REPEATING.
  - REPEATING: key_repeat pulses every REPEAT_PERIOD_CYCLES cycles while held and repeat_en = 1.
  - Any state -> RELEASED on accepted release; key_release pulses and the repeat counter clears.
  - repeat_en = 0 in HELD_WAIT or REPEATING holds the repeat counter at 0 and suppresses key_repeat. The FSM stays in its current state. When repeat_en returns to 1, counting restarts from 0 against that state's threshold.
- Repeat counter width is clog2 of max(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES). It never wraps, because it clears on each threshold.
- key_press, key_release and key_repeat are mutually exclusive per key in any cycle. key_repeat never occurs in the same cycle as key_press.

## Timing
- All outputs are registered.
- Reset values: key_level = 0, key_press = 0, key_release = 0, key_repeat = 0, FSM = RELEASED, all counters = 0, synchroniser = 0.
- Reset is synchronous. Asserting it mid-press returns the channel to RELEASED with no release pulse. If the key is still held after reset deasserts, it is re-accepted as a fresh press after the full debounce time.
- Press latency: key_n first sampled low at edge k and stable thereafter gives key_level = 1 and key_press = 1 after edge k+1+DEBOUNCE_CYCLES. This is 2 cycles of synchroniser plus DEBOUNCE_CYCLES-1 counting cycles plus 1 toggle edge.
- Release latency is identical.
- First key_repeat occurs REPEAT_DELAY_CYCLES cycles after the key_press cycle. Later repeats occur every REPEAT_PERIOD_CYCLES cycles.
- Pulses are one CLK_50MHz cycle wide. The consumer in the 100 Hz domain must stretch or capture them; that is out of scope here.

## Structure
- Shared package stopwatch_pkg holds the default cycle constants (DEBOUNCE_20MS, REPEAT_DELAY_0_5S, REPEAT_PERIOD_0_1S) and the channel state enum (KEY_RELEASED, KEY_HELD_WAIT, KEY_REPEATING).
- One sub-module, key_channel, implements the synchroniser, debounce counter, FSM and repeat counter for a single key. The top-level block instantiates it NUM_KEYS times with a generate loop.

## Test plan
Use DEBOUNCE_CYCLES = 4, REPEAT_DELAY_CYCLES = 10, REPEAT_PERIOD_CYCLES = 3 and NUM_KEYS = 2 throughout.
1. Reset: hold reset_n = 0 with key_n = 2'b00 -> all outputs 0. After release of reset with keys held, key_press[1:0] = 2'b11 exactly 5 cycles after the first sampled-low edge.
2. Clean press on key0 at edge k -> key_press[0] is high only after edge k+5 and key_level[0] = 1. Release -> key_release[0] 5 cycles later, key_level[0] = 0.
3. Bounce: key_n[0] toggles low/high every 2 cycles for 20 cycles, then stays high -> no key_press and no key_level change.
4. Auto-repeat with repeat_en[0] = 1, held for 30 cycles after key_press -> key_repeat[0] at +10, +13, +16, +19, +22, +25, +28 cycles. With repeat_en[0] = 0 -> no key_repeat.
5. Simultaneous: key0 pressed 2 cycles before key1 -> independent key_press pulses 2 cycles apart. No cross-effect on levels or repeats.
6. Mid-operation reset: reset_n = 0 for 1 cycle while in REPEATING -> outputs 0, no key_release. The held key is re-accepted 5 cycles after reset deasserts.
